seq_mul_add: RTL and testbench

//  Sequential unsigned multiply-add: result = multiplicand * multiplier + addend.

---
 rtl/arith_pkg.sv | 12 +
 rtl/mul_add_step.sv | 23 ++
 rtl/seq_mul_add.sv | 104 ++++++++++
 tb/tb_seq_mul_add.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the multiply-add unit and the divider.
// Holds the default operand width and the sequencer state encoding.
package arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mul_add_step.sv
// One radix-2 shift-add step of the sequential multiply-add.
// Ports:
//   i_acc         2*WIDTH  running accumulator
//   i_mcand       2*WIDTH  multiplicand, already shifted to the current bit weight
//   i_mplier_lsb  1        current multiplier bit
//   o_acc_next    2*WIDTH  accumulator after conditionally adding the multiplicand
//   o_mcand_next  2*WIDTH  multiplicand shifted left by one for the next bit
module mul_add_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [2*WIDTH-1:0] i_mcand,
  input  logic               i_mplier_lsb,
  output logic [2*WIDTH-1:0] o_acc_next,
  output logic [2*WIDTH-1:0] o_mcand_next
);

  always_comb begin
    o_acc_next   = i_mplier_lsb ? (i_acc + i_mcand) : i_acc;
    o_mcand_next = i_mcand << 1;
  end

endmodule

// File: rtl/seq_mul_add.sv
// Sequential unsigned multiply-add: result = multiplicand * multiplier + addend.
// One multiplier bit per clock; WIDTH clocks from the start-sampling edge to the
// edge that raises done. Also used to rebuild Dividend from divider outputs.
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous active-low reset
//   start         operation request, sampled only while idle
//   multiplicand  operand A
//   multiplier    operand B
//   addend        operand C
//   busy          high while an operation is in progress
//   done          one-cycle pulse when result/overflow are updated
//   result        A*B+C, 2*WIDTH bits, held until the next completion
//   overflow      upper half of result is non-zero
module seq_mul_add
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   addend,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CW-1:0]        r_count;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_overflow;

  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   w_mcand_next;

  mul_add_step #(.WIDTH(WIDTH)) u_step (
    .i_acc        (r_acc),
    .i_mcand      (r_mcand),
    .i_mplier_lsb (r_mplier[0]),
    .o_acc_next   (w_acc_next),
    .o_mcand_next (w_mcand_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc    <= {{WIDTH{1'b0}}, addend};
            r_mcand  <= {{WIDTH{1'b0}}, multiplicand};
            r_mplier <= multiplier;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= w_mcand_next;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
          // Final step: publish the post-add accumulator, not the registered one.
          if (r_count == LAST) begin
            r_result   <= w_acc_next;
            r_overflow <= |w_acc_next[2*WIDTH-1:WIDTH];
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_seq_mul_add.sv
module tb_seq_mul_add;

  localparam int W = 64;
  localparam int BUDGET = 200;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           ovf;
  } exp_t;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [W-1:0]   addend;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           overflow;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  seq_mul_add #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_mac(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    exp_t e;
    e.res = (2*W)'(a) * (2*W)'(b) + (2*W)'(c);
    e.ovf = (e.res >> W) != 0;
    return e;
  endfunction

  // Drive one request, push its expectation, leave start low after the sampling edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                          input exp_t e);
    multiplicand = a;
    multiplier   = b;
    addend       = c;
    start        = 1'b1;
    sb.push_back(e);
    tick();
    start = 1'b0;
  endtask

  // Returns cycles from the sampling edge to done, and how many of those cycles had busy high.
  task automatic wait_done(output int lat, output int busyc);
    lat = 0;
    busyc = 0;
    while (!done && lat < BUDGET) begin
      if (busy) busyc++;
      tick();
      lat++;
    end
  endtask

  task automatic finish_op(input string tag);
    int   lat;
    int   busyc;
    exp_t e;
    wait_done(lat, busyc);
    check({tag, " latency"}, (2*W)'(lat), (2*W)'(W));
    check({tag, " busy at done"}, (2*W)'(busy), '0);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s scoreboard: observed empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " result"}, result, e.res);
      check({tag, " overflow"}, (2*W)'(overflow), (2*W)'(e.ovf));
    end
  endtask

  initial begin
    exp_t e;
    int   lat;
    int   busyc;
    int   dones;
    logic [W-1:0] a, b, c, dvd, dvs;

    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    addend       = '0;
    repeat (3) tick();
    check("reset busy", (2*W)'(busy), '0);
    check("reset done", (2*W)'(done), '0);
    check("reset result", result, '0);
    check("reset overflow", (2*W)'(overflow), '0);
    reset = 1'b1;
    tick();

    // 1: small product, latency and busy span
    e.res = 128'd87;
    e.ovf = 1'b0;
    start_op(64'd5, 64'd17, 64'd2, e);
    wait_done(lat, busyc);
    check("t1 latency", (2*W)'(lat), (2*W)'(W));
    check("t1 busy cycles", (2*W)'(busyc), (2*W)'(W));
    e = sb.pop_front();
    check("t1 result", result, e.res);
    check("t1 overflow", (2*W)'(overflow), (2*W)'(e.ovf));
    tick();
    check("t1 done pulse width", (2*W)'(done), '0);
    check("t1 result held", result, 128'd87);

    // 2: result fills exactly the low half
    e.res = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
    e.ovf = 1'b0;
    start_op(64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, e);
    finish_op("t2");

    // 3: maximum operands
    e.res = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000;
    e.ovf = 1'b1;
    start_op('1, '1, '1, e);
    finish_op("t3");

    // 4: zero multiplicand, start pulses while busy are ignored, done-cycle start accepted
    tick();
    e.res = 128'd9;
    e.ovf = 1'b0;
    start_op(64'd0, 64'd123, 64'd9, e);
    lat = 0;
    while (!done && lat < BUDGET) begin
      if (lat == 10 || lat == 30) begin
        multiplicand = 64'd7;
        multiplier   = 64'd7;
        addend       = 64'd7;
        start        = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check("t4 latency", (2*W)'(lat), (2*W)'(W));
    e = sb.pop_front();
    check("t4 result", result, e.res);
    check("t4 overflow", (2*W)'(overflow), (2*W)'(e.ovf));
    start_op(64'd11, 64'd13, 64'd17, ref_mac(64'd11, 64'd13, 64'd17));
    check("t4 done-cycle start busy", (2*W)'(busy), 128'd1);
    finish_op("t4b");

    // 5: reset mid-operation clears everything; no completion without a new start
    start_op(64'd3, 64'd4, 64'd0, ref_mac(64'd3, 64'd4, 64'd0));
    void'(sb.pop_back());
    repeat (19) tick();
    #2 reset = 1'b0;
    #1;
    check("t5 reset busy", (2*W)'(busy), '0);
    check("t5 reset done", (2*W)'(done), '0);
    check("t5 reset result", result, '0);
    check("t5 reset overflow", (2*W)'(overflow), '0);
    tick();
    reset = 1'b1;
    dones = 0;
    repeat (2*W) begin
      tick();
      if (done) dones++;
    end
    check("t5 no done after reset", (2*W)'(dones), '0);
    check("t5 busy idle", (2*W)'(busy), '0);

    // 6a: random operands against the 128-bit reference
    for (int i = 0; i < 1000; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = {$urandom, $urandom};
      if (i % 10 == 1) a = '1;
      if (i % 10 == 2) b = '0;
      if (i % 10 == 3) c = '1;
      start_op(a, b, c, ref_mac(a, b, c));
      finish_op("rand");
    end

    // 6b: divider reconstruction, Divisor*Quotient+Remainder must equal Dividend
    for (int i = 0; i < 40; i++) begin
      dvd = {$urandom, $urandom};
      dvs = {$urandom, $urandom} >> $urandom_range(63, 0);
      if (dvs == 0) dvs = 64'd1;
      e.res = (2*W)'(dvd);
      e.ovf = 1'b0;
      start_op(dvs, dvd / dvs, dvd % dvs, e);
      finish_op("div rebuild");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
